sts_pack: RTL and testbench
===========================

Name: sts_pack

Overview:
- Status-direction counterpart of the configuration unpacker: collects live status from the ADC pipeline and packs it into one flat sts_data word for the PS status register bank.
- Owns the trigger event counter, the peak hold of |A|+|B|, the sticky clip flags and a snapshot (freeze) mechanism, so software can read a multi-word status coherently.
- Sits between the ADC/trigger/writer cores and the AXI status register.

Parameters:
- STS_DATA_WIDTH, 160, packed status width; must be >= 128; bits above the defined fields read 0.
- WR_ADDR_WIDTH, 32, width of the writer address field.
- TRG_CNT_WIDTH, 32, width of the trigger counter.
- MAX_SUM_WIDTH, 17, width of the |A|+|B| peak field.
- Elaboration-time check: each field LSB+WIDTH <= STS_DATA_WIDTH; $error otherwise.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- wr_addr  in  WR_ADDR_WIDTH  current axis writer address.
- trg_pulse  in  1  one-cycle trigger event strobe.
- nreset_trg  in  1  synchronous clear of trigger count and overflow flag, active low.
- sum_abs  in  MAX_SUM_WIDTH  unsigned |A|+|B| sample.
- sum_valid  in  1  qualifies sum_abs.
- nreset_max_sum  in  1  synchronous clear of peak and clip flags, active low.
- clip_a  in  1  limiter clipped channel A this cycle.
- clip_b  in  1  limiter clipped channel B this cycle.
- freeze  in  1  level: 1 holds the snapshot, 0 tracks live.
- sts_data  out  STS_DATA_WIDTH  packed status word.
- frozen  out  1  1 while in HOLD.

Behaviour:
- Reset (aresetn=0, async): trg_cnt=0, trg_ovf=0, max_sum=0, clip_a_st=0, clip_b_st=0, snap_seq=0, state=LIVE, sts_data=0, frozen=0.
- Trigger counter:
  - nreset_trg=0 clears trg_cnt and trg_ovf; the clear has priority over a same-cycle trg_pulse.
  - Otherwise trg_pulse increments trg_cnt.
  - At all-ones the counter saturates (no wrap) and trg_ovf sets sticky.
- Peak hold:
  - nreset_max_sum=0 clears max_sum, clip_a_st and clip_b_st, with priority.
  - Otherwise, if sum_valid and sum_abs > max_sum, then max_sum <= sum_abs. Equal values leave it unchanged.
  - clip_a / clip_b set their sticky flags.
- Packing (LSB first):
  - [31:0] wr_addr
  - [63:32] trg_cnt
  - [80:64] max_sum
  - [95:81] 0
  - [96] clip_a_st
  - [97] clip_b_st
  - [98] trg_ovf
  - [103:99] 0
  - [111:104] snap_seq
  - [127:112] 0
  - [159:128] see Optional Feature
- State machine:
  - LIVE: sts_data <= packed live values every cycle. This gives 1-cycle latency from the internal register to sts_data, i.e. 2 cycles from the input event.
  - LIVE -> HOLD when freeze=1. On that edge sts_data captures the packed live values, snap_seq increments (8-bit, wraps 255->0) and is included in the captured word, and frozen <= 1.
  - HOLD: sts_data is unchanged. Internal counters, peak and sticky flags keep updating.
  - HOLD -> LIVE when freeze=0: frozen <= 0 and sts_data resumes tracking on that edge.
  - A freeze pulse of exactly 1 cycle gives one HOLD cycle and one snap_seq increment.
- Clears while in HOLD affect internal state only. The frozen word is unaffected until LIVE.
- Async reset mid-HOLD returns to LIVE with all outputs 0.

Optional Feature:
- Macro: STS_PACK_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter ts is reset to 0 by aresetn and increments every cycle, wrapping.
  - ts is packed at [159:128] and is captured with the snapshot like the other fields.
  - Requires STS_DATA_WIDTH >= 160 ($error otherwise).
- Undefined: no counter is built and bits [159:128] read 0.

Test Plan:
- Reset, then 5 trg_pulse with nreset_trg=1 -> sts_data[63:32]=5 two cycles after the last pulse. Then pulse nreset_trg=0 together with trg_pulse -> field = 0.
- Force trg_cnt to 0xFFFFFFFE, then 3 trg_pulse -> field = 0xFFFFFFFF and bit98=1. nreset_trg=0 -> both clear.
- sum_abs sequence 100, 250, 250, 30 with sum_valid=1 -> [80:64]=250. Same sequence with sum_valid=0 on the 250 samples -> 100. nreset_max_sum=0 -> 0.
- freeze=1 with wr_addr=0x1000, then wr_addr changes to 0x2000 and 2 trg_pulse occur during HOLD:
  - during HOLD: sts_data[31:0]=0x1000, [111:104]=1, frozen=1;
  - after freeze=0: next cycle shows 0x2000 and a count +2.
- 256 single-cycle freeze pulses -> snap_seq wraps back to 0. clip_a pulse for 1 cycle -> bit96 stays 1 until nreset_max_sum=0.
- Timestamp:
  - with STS_PACK_TIMESTAMP_EN defined: freeze at cycle N -> [159:128] is constant while frozen and increments again after release;
  - undefined: [159:128]=0 always.

Source files
------------

// File: rtl/sts_pack.sv
// Status packer: trigger counter, |A|+|B| peak hold, sticky clip flags and a
// freeze/snapshot register feeding the PS status bank. Optional timestamp: STS_PACK_TIMESTAMP_EN.
module sts_pack #(
    parameter int STS_DATA_WIDTH = 160,
    parameter int WR_ADDR_WIDTH  = 32,
    parameter int TRG_CNT_WIDTH  = 32,
    parameter int MAX_SUM_WIDTH  = 17
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [WR_ADDR_WIDTH-1:0]  wr_addr,
    input  logic                      trg_pulse,
    input  logic                      nreset_trg,
    input  logic [MAX_SUM_WIDTH-1:0]  sum_abs,
    input  logic                      sum_valid,
    input  logic                      nreset_max_sum,
    input  logic                      clip_a,
    input  logic                      clip_b,
    input  logic                      freeze,
    output logic [STS_DATA_WIDTH-1:0] sts_data,
    output logic                      frozen
);

    localparam int TRG_LSB   = 32;
    localparam int MAX_LSB   = 64;
    localparam int CLIPA_BIT = 96;
    localparam int CLIPB_BIT = 97;
    localparam int OVF_BIT   = 98;
    localparam int SNAP_LSB  = 104;
    localparam int SNAP_W    = 8;
    localparam int TS_LSB    = 128;
    localparam int TS_W      = 32;

    typedef enum logic {LIVE, HOLD} state_t;

    if (STS_DATA_WIDTH < 128) begin : g_chk_width
        $error("sts_pack: STS_DATA_WIDTH must be >= 128");
    end
    if (WR_ADDR_WIDTH > STS_DATA_WIDTH) begin : g_chk_wr
        $error("sts_pack: wr_addr field exceeds STS_DATA_WIDTH");
    end
    if (TRG_LSB + TRG_CNT_WIDTH > STS_DATA_WIDTH) begin : g_chk_trg
        $error("sts_pack: trg_cnt field exceeds STS_DATA_WIDTH");
    end
    if (MAX_LSB + MAX_SUM_WIDTH > STS_DATA_WIDTH) begin : g_chk_max
        $error("sts_pack: max_sum field exceeds STS_DATA_WIDTH");
    end
    if (SNAP_LSB + SNAP_W > STS_DATA_WIDTH) begin : g_chk_snap
        $error("sts_pack: snap_seq field exceeds STS_DATA_WIDTH");
    end

    logic [TRG_CNT_WIDTH-1:0]  trg_cnt_q, trg_cnt_d;
    logic                      trg_ovf_q, trg_ovf_d;
    logic [MAX_SUM_WIDTH-1:0]  max_sum_q, max_sum_d;
    logic                      clip_a_st_q, clip_a_st_d;
    logic                      clip_b_st_q, clip_b_st_d;
    logic [SNAP_W-1:0]         snap_seq_q, snap_seq_d;
    state_t                    state_q, state_d;
    logic [STS_DATA_WIDTH-1:0] sts_data_q, sts_data_d;
    logic                      frozen_q, frozen_d;
    logic [STS_DATA_WIDTH-1:0] live_word;
    logic                      load_live;
`ifdef STS_PACK_TIMESTAMP_EN
    logic [TS_W-1:0]           ts_q, ts_d;

    if (TS_LSB + TS_W > STS_DATA_WIDTH) begin : g_chk_ts
        $error("sts_pack: timestamp requires STS_DATA_WIDTH >= 160");
    end

    assign ts_d = ts_q + TS_W'(1);
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        trg_cnt_d = trg_cnt_q;
        trg_ovf_d = trg_ovf_q;
        if (!nreset_trg) begin
            trg_cnt_d = '0;
            trg_ovf_d = 1'b0;
        end else if (trg_pulse) begin
            // A pulse that finds the counter full is a lost event: hold and flag it.
            if (&trg_cnt_q) trg_ovf_d = 1'b1;
            else            trg_cnt_d = trg_cnt_q + TRG_CNT_WIDTH'(1);
        end
    end

    always_comb begin
        max_sum_d   = max_sum_q;
        clip_a_st_d = clip_a_st_q;
        clip_b_st_d = clip_b_st_q;
        if (!nreset_max_sum) begin
            max_sum_d   = '0;
            clip_a_st_d = 1'b0;
            clip_b_st_d = 1'b0;
        end else begin
            if (sum_valid && (sum_abs > max_sum_q)) max_sum_d = sum_abs;
            if (clip_a) clip_a_st_d = 1'b1;
            if (clip_b) clip_b_st_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_seq_d = snap_seq_q;
        frozen_d   = frozen_q;
        load_live  = 1'b0;
        case (state_q)
            LIVE: begin
                load_live = 1'b1;
                if (freeze) begin
                    state_d    = HOLD;
                    snap_seq_d = snap_seq_q + SNAP_W'(1);
                    frozen_d   = 1'b1;
                end
            end
            HOLD: begin
                if (!freeze) begin
                    state_d   = LIVE;
                    frozen_d  = 1'b0;
                    load_live = 1'b1;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    // snap_seq_d is packed so the capturing edge already carries the new sequence number.
    always_comb begin
        live_word                            = '0;
        live_word[WR_ADDR_WIDTH-1:0]         = wr_addr;
        live_word[TRG_LSB +: TRG_CNT_WIDTH]  = trg_cnt_q;
        live_word[MAX_LSB +: MAX_SUM_WIDTH]  = max_sum_q;
        live_word[CLIPA_BIT]                 = clip_a_st_q;
        live_word[CLIPB_BIT]                 = clip_b_st_q;
        live_word[OVF_BIT]                   = trg_ovf_q;
        live_word[SNAP_LSB +: SNAP_W]        = snap_seq_d;
`ifdef STS_PACK_TIMESTAMP_EN
        live_word[TS_LSB +: TS_W]            = ts_q;
`endif
        sts_data_d = load_live ? live_word : sts_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            trg_cnt_q   <= '0;
            trg_ovf_q   <= 1'b0;
            max_sum_q   <= '0;
            clip_a_st_q <= 1'b0;
            clip_b_st_q <= 1'b0;
            snap_seq_q  <= '0;
            state_q     <= LIVE;
            sts_data_q  <= '0;
            frozen_q    <= 1'b0;
`ifdef STS_PACK_TIMESTAMP_EN
            ts_q        <= '0;
`endif
        end else begin
            trg_cnt_q   <= trg_cnt_d;
            trg_ovf_q   <= trg_ovf_d;
            max_sum_q   <= max_sum_d;
            clip_a_st_q <= clip_a_st_d;
            clip_b_st_q <= clip_b_st_d;
            snap_seq_q  <= snap_seq_d;
            state_q     <= state_d;
            sts_data_q  <= sts_data_d;
            frozen_q    <= frozen_d;
`ifdef STS_PACK_TIMESTAMP_EN
            ts_q        <= ts_d;
`endif
        end
    end

    assign sts_data = sts_data_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_sts_pack.sv
// Self-checking bench for sts_pack: directed test-plan scenarios plus random
// stimulus against a rule-level reference model; a 3-bit-counter instance exercises saturation.
module tb_sts_pack;

    localparam int SMALL_TRG_W = 3;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  wr_addr;
    logic         trg_pulse, nreset_trg;
    logic [16:0]  sum_abs;
    logic         sum_valid, nreset_max_sum;
    logic         clip_a, clip_b, freeze;
    logic [159:0] sts_data, sts_data_s;
    logic         frozen, frozen_s;

    always #5 aclk = ~aclk;

    sts_pack dut (
        .aclk(aclk), .aresetn(aresetn), .wr_addr(wr_addr), .trg_pulse(trg_pulse),
        .nreset_trg(nreset_trg), .sum_abs(sum_abs), .sum_valid(sum_valid),
        .nreset_max_sum(nreset_max_sum), .clip_a(clip_a), .clip_b(clip_b),
        .freeze(freeze), .sts_data(sts_data), .frozen(frozen)
    );

    sts_pack #(.TRG_CNT_WIDTH(SMALL_TRG_W)) dut_s (
        .aclk(aclk), .aresetn(aresetn), .wr_addr(wr_addr), .trg_pulse(trg_pulse),
        .nreset_trg(nreset_trg), .sum_abs(sum_abs), .sum_valid(sum_valid),
        .nreset_max_sum(nreset_max_sum), .clip_a(clip_a), .clip_b(clip_b),
        .freeze(freeze), .sts_data(sts_data_s), .frozen(frozen_s)
    );

    typedef struct {
        longint unsigned cnt;
        longint unsigned cnt_max;
        bit              ovf;
        int unsigned     peak;
        bit              ca;
        bit              cb;
        int unsigned     snap;
        bit              hold;
        logic [159:0]    exp;
    } model_t;

    model_t      mb, ms;
    logic [31:0] ts_m;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic model_t model_init(input longint unsigned cnt_max);
        model_t m;
        m.cnt = 0; m.cnt_max = cnt_max; m.ovf = 0; m.peak = 0;
        m.ca = 0; m.cb = 0; m.snap = 0; m.hold = 0; m.exp = '0;
        return m;
    endfunction

    function automatic logic [159:0] pack_word(input model_t m, input logic [31:0] addr,
                                               input int unsigned snap, input logic [31:0] ts);
        logic [159:0] w;
        logic [31:0]  c32;
        logic [31:0]  p32;
        logic [31:0]  s32;
        w   = '0;
        c32 = m.cnt[31:0];
        p32 = m.peak;
        s32 = snap;
        w[31:0]    = addr;
        w[63:32]   = c32;
        w[80:64]   = p32[16:0];
        w[96]      = m.ca;
        w[97]      = m.cb;
        w[98]      = m.ovf;
        w[111:104] = s32[7:0];
`ifdef STS_PACK_TIMESTAMP_EN
        w[159:128] = ts;
`else
        if (ts != ts) w = 'x;  // ts only matters with the timestamp build
`endif
        return w;
    endfunction

    // One rising edge: the visible word is built from the pre-edge state, then state advances.
    function automatic model_t model_step(input model_t m, input logic [31:0] ts);
        model_t n;
        n = m;
        if (!m.hold) begin
            if (freeze) begin
                n.snap = (m.snap + 1) % 256;
                n.hold = 1;
            end
            n.exp = pack_word(m, wr_addr, n.snap, ts);
        end else if (!freeze) begin
            n.hold = 0;
            n.exp  = pack_word(m, wr_addr, m.snap, ts);
        end
        if (!nreset_trg) begin
            n.cnt = 0; n.ovf = 0;
        end else if (trg_pulse) begin
            if (m.cnt == m.cnt_max) n.ovf = 1;
            else                    n.cnt = m.cnt + 1;
        end
        if (!nreset_max_sum) begin
            n.peak = 0; n.ca = 0; n.cb = 0;
        end else begin
            if (sum_valid && (int'(sum_abs) > m.peak)) n.peak = sum_abs;
            if (clip_a) n.ca = 1;
            if (clip_b) n.cb = 1;
        end
        return n;
    endfunction

    task automatic set_idle();
        wr_addr = '0; trg_pulse = 0; nreset_trg = 1; sum_abs = '0; sum_valid = 0;
        nreset_max_sum = 1; clip_a = 0; clip_b = 0; freeze = 0;
    endtask

    task automatic tick();
        @(posedge aclk);
        mb = model_step(mb, ts_m);
        ms = model_step(ms, ts_m);
        ts_m = ts_m + 32'd1;
        @(negedge aclk);
        check("sts_data", sts_data, mb.exp);
        check("frozen", 160'(frozen), 160'(mb.hold));
        check("sts_data_sat", sts_data_s, ms.exp);
        check("frozen_sat", 160'(frozen_s), 160'(ms.hold));
    endtask

    task automatic do_reset();
        aresetn = 0;
        set_idle();
        #2;
        check("rst_sts", sts_data, '0);
        check("rst_frozen", 160'(frozen), '0);
        mb = model_init(64'hFFFF_FFFF);
        ms = model_init((64'd1 << SMALL_TRG_W) - 1);
        ts_m = '0;
        @(negedge aclk);
        aresetn = 1;
    endtask

    task automatic feed_sums(input bit valid_250);
        int unsigned seq [4] = '{100, 250, 250, 30};
        for (int i = 0; i < 4; i++) begin
            sum_abs   = 17'(seq[i]);
            sum_valid = (seq[i] == 250) ? valid_250 : 1'b1;
            tick();
        end
        sum_valid = 0;
        tick(); tick();
    endtask

    initial begin
        logic [31:0] ts_cap;
        set_idle();
        do_reset();

        // Trigger count and clear priority
        repeat (5) begin trg_pulse = 1; tick(); end
        trg_pulse = 0;
        tick(); tick();
        check("trg_cnt_5", 160'(sts_data[63:32]), 160'd5);
        trg_pulse = 1; nreset_trg = 0; tick();
        trg_pulse = 0; nreset_trg = 1; tick(); tick();
        check("trg_clr", 160'(sts_data[63:32]), 160'd0);

        // Saturation on the 3-bit instance
        repeat (10) begin trg_pulse = 1; tick(); end
        trg_pulse = 0;
        tick(); tick();
        check("sat_cnt", 160'(sts_data_s[63:32]), 160'd7);
        check("sat_ovf", 160'(sts_data_s[98]), 160'd1);
        check("big_cnt_10", 160'(sts_data[63:32]), 160'd10);
        check("big_no_ovf", 160'(sts_data[98]), 160'd0);
        nreset_trg = 0; tick();
        nreset_trg = 1; tick(); tick();
        check("sat_clr_cnt", 160'(sts_data_s[63:32]), 160'd0);
        check("sat_clr_ovf", 160'(sts_data_s[98]), 160'd0);
        repeat (10) begin trg_pulse = 1; tick(); end
        trg_pulse = 0;

        // Peak hold
        feed_sums(1'b1);
        check("peak_250", 160'(sts_data[80:64]), 160'd250);
        nreset_max_sum = 0; tick(); nreset_max_sum = 1;
        feed_sums(1'b0);
        check("peak_100", 160'(sts_data[80:64]), 160'd100);
        nreset_max_sum = 0; tick(); nreset_max_sum = 1; tick(); tick();
        check("peak_clr", 160'(sts_data[80:64]), 160'd0);

        // Freeze with live changes underneath
        wr_addr = 32'h1000; tick();
        freeze = 1; ts_cap = ts_m; tick();
        wr_addr = 32'h2000;
        trg_pulse = 1; tick(); tick();
        trg_pulse = 0; tick();
        check("hold_addr", 160'(sts_data[31:0]), 160'h1000);
        check("hold_snap", 160'(sts_data[111:104]), 160'd1);
        check("hold_frozen", 160'(frozen), 160'd1);
        check("hold_cnt", 160'(sts_data[63:32]), 160'd10);
`ifdef STS_PACK_TIMESTAMP_EN
        check("hold_ts", 160'(sts_data[159:128]), 160'(ts_cap));
`else
        check("ts_zero", 160'(sts_data[159:128]), 160'd0);
`endif
        freeze = 0; ts_cap = ts_m; tick();
        check("rel_addr", 160'(sts_data[31:0]), 160'h2000);
        check("rel_cnt", 160'(sts_data[63:32]), 160'd12);
        check("rel_frozen", 160'(frozen), 160'd0);
`ifdef STS_PACK_TIMESTAMP_EN
        check("rel_ts", 160'(sts_data[159:128]), 160'(ts_cap));
        tick();
        check("rel_ts_run", 160'(sts_data[159:128]), 160'(ts_cap + 32'd1));
`endif

        // Async reset while frozen
        freeze = 1; tick(); tick();
        #3;
        do_reset();

        // snap_seq wrap after 256 single-cycle freezes
        repeat (256) begin freeze = 1; tick(); freeze = 0; tick(); end
        check("snap_wrap", 160'(sts_data[111:104]), 160'd0);
        freeze = 1; tick(); freeze = 0; tick();
        check("snap_after", 160'(sts_data[111:104]), 160'd1);

        // Sticky clip flag
        clip_a = 1; tick(); clip_a = 0;
        repeat (20) tick();
        check("clip_a_sticky", 160'(sts_data[96]), 160'd1);
        check("clip_b_clear", 160'(sts_data[97]), 160'd0);
        nreset_max_sum = 0; tick(); nreset_max_sum = 1; tick(); tick();
        check("clip_a_clr", 160'(sts_data[96]), 160'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            wr_addr        = $urandom;
            trg_pulse      = $urandom_range(0, 1) == 1;
            nreset_trg     = $urandom_range(0, 63) != 0;
            sum_valid      = $urandom_range(0, 1) == 1;
            sum_abs        = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'($urandom_range(0, 4000));
            nreset_max_sum = $urandom_range(0, 63) != 0;
            clip_a         = $urandom_range(0, 31) == 0;
            clip_b         = $urandom_range(0, 31) == 0;
            if ($urandom_range(0, 7) == 0) freeze = ~freeze;
            if (i == 1500) do_reset();
            else           tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
